// File: rtl/jsilicon_pkg.sv
// Shared definitions for the jsilicon serial path: UART framing constants
// and the receiver state encoding.
package jsilicon_pkg;

  localparam int UART_DATA_BITS    = 8;
  // Shared with the transmitter so both ends run at the same baud rate.
  localparam int UART_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    RECOVER
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for bringing an asynchronous pin into the clk domain.
// RESET_VAL is the line's inactive level, so reset releases without a glitch.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver feeding the core through a one-entry holding register
// with a valid/ready handshake; flags framing errors and dropped bytes.
module uart_rx
  import jsilicon_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int CNT_W        = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      frame_err,
  output logic                      overrun,
  output logic                      busy
);

  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

  logic                      rx_s;
  rx_state_t                 state;
  logic [CNT_W-1:0]          cnt;
  logic [IDX_W-1:0]          bit_idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic                      good_byte;

  sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  // Stop bit sampled high on an enabled frame: hand the byte to the holding register.
  assign good_byte = ena && (state == STOP) && (cnt == FULL_CNT) && rx_s;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (!ena) begin
        state   <= IDLE;
        cnt     <= '0;
        bit_idx <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state <= START;
              cnt   <= '0;
            end
          end
          START: begin
            if (cnt == HALF_CNT) begin
              cnt     <= '0;
              bit_idx <= '0;
              state   <= rx_s ? IDLE : DATA;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DATA: begin
            if (cnt == FULL_CNT) begin
              cnt            <= '0;
              shift[bit_idx] <= rx_s;
              if (bit_idx == LAST_IDX) begin
                state <= STOP;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          STOP: begin
            if (cnt == FULL_CNT) begin
              cnt <= '0;
              if (rx_s) begin
                state <= IDLE;
              end else begin
                state     <= RECOVER;
                frame_err <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RECOVER: begin
            if (rx_s) begin
              state <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  // A consumer draining the register in the same cycle makes room for the new byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (good_byte) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
